// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_stage
// Purpose  : RV32I decode / operand-fetch stage sitting directly upstream of
//            register_file. Drives the register file read indices, selects
//            operands (with same-cycle writeback bypass), tracks pending
//            destinations in a scoreboard, stalls on RAW hazards and registers
//            the payload for execute.
// Ports    : of_clk, of_ares_n          clock / async active-low reset
//            if_valid/if_ready          fetch-side handshake
//            if_instr, if_pc            fetched instruction and its PC
//            rf_ra_dec, rf_rb_dec       rs1/rs2 indices to register_file
//            rf_qa, rf_qb               register_file read data
//            wb_en, wb_rd, wb_data      writeback (same as register_file write)
//            ex_valid/ex_ready          execute-side handshake
//            ex_instr, ex_pc            registered instruction / PC
//            ex_rs1_val, ex_rs2_val     registered operands
//            ex_rd                      destination (0 = no register write)
//            ex_illegal                 opcode outside the RV32I base set
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_W       = 32
) (
  input  logic                  of_clk,
  input  logic                  of_ares_n,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [31:0]           if_instr,
  input  logic [PC_W-1:0]       if_pc,
  output logic [ADDR_WIDTH-1:0] rf_ra_dec,
  output logic [ADDR_WIDTH-1:0] rf_rb_dec,
  input  logic [XLEN-1:0]       rf_qa,
  input  logic [XLEN-1:0]       rf_qb,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [31:0]           ex_instr,
  output logic [PC_W-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_val,
  output logic [XLEN-1:0]       ex_rs2_val,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  ex_illegal
);

  localparam int         c_NREGS      = 1 << ADDR_WIDTH;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;

  // Instruction fields
  logic [6:0]            w_opcode;
  logic [ADDR_WIDTH-1:0] w_rs1;
  logic [ADDR_WIDTH-1:0] w_rs2;
  logic [ADDR_WIDTH-1:0] w_rd;

  assign w_opcode = if_instr[6:0];
  assign w_rs1    = if_instr[15 +: ADDR_WIDTH];
  assign w_rs2    = if_instr[20 +: ADDR_WIDTH];
  assign w_rd     = if_instr[7 +: ADDR_WIDTH];

  assign rf_ra_dec = w_rs1;
  assign rf_rb_dec = w_rs2;

  // Opcode class decode
  logic w_use_rs1;
  logic w_use_rs2;
  logic w_wr_rd;
  logic w_illegal;

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_wr_rd   = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      c_OPC_LUI, c_OPC_AUIPC, c_OPC_JAL: w_wr_rd = 1'b1;
      c_OPC_JALR, c_OPC_LOAD, c_OPC_OPIMM: begin
        w_use_rs1 = 1'b1;
        w_wr_rd   = 1'b1;
      end
      c_OPC_BRANCH, c_OPC_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      c_OPC_OP: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_wr_rd   = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // State
  logic                  r_ex_valid;
  logic [31:0]           r_ex_instr;
  logic [PC_W-1:0]       r_ex_pc;
  logic [XLEN-1:0]       r_ex_rs1_val;
  logic [XLEN-1:0]       r_ex_rs2_val;
  logic [ADDR_WIDTH-1:0] r_ex_rd;
  logic                  r_ex_illegal;
  logic [c_NREGS-1:0]    r_sb;

  // Operand select. The register file write lands only on the next edge, so a
  // writeback to the same index this cycle must be forwarded from wb_data.
  logic            w_act_a;
  logic            w_act_b;
  logic            w_byp_a;
  logic            w_byp_b;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;

  assign w_act_a = w_use_rs1 && (w_rs1 != '0);
  assign w_act_b = w_use_rs2 && (w_rs2 != '0);
  assign w_byp_a = wb_en && (wb_rd == w_rs1);
  assign w_byp_b = wb_en && (wb_rd == w_rs2);
  assign w_op_a  = !w_act_a ? '0 : (w_byp_a ? wb_data : rf_qa);
  assign w_op_b  = !w_act_b ? '0 : (w_byp_b ? wb_data : rf_qb);

  // A pending source is harmless when its writeback arrives this same cycle,
  // since the bypass above supplies the value.
  logic w_stall;
  logic w_accept;
  logic [ADDR_WIDTH-1:0] w_dest;

  assign w_stall  = (w_act_a && r_sb[w_rs1] && !w_byp_a) ||
                    (w_act_b && r_sb[w_rs2] && !w_byp_b);
  assign if_ready = !w_stall && (!r_ex_valid || ex_ready);
  assign w_accept = if_valid && if_ready;
  assign w_dest   = (w_wr_rd && (w_rd != '0)) ? w_rd : '0;

  // Clear before set so a new writer of the same index stays pending.
  logic [c_NREGS-1:0] w_sb_next;

  always_comb begin
    w_sb_next = r_sb;
    if (wb_en && (wb_rd != '0)) begin
      w_sb_next[wb_rd] = 1'b0;
    end
    if (w_accept && (w_dest != '0)) begin
      w_sb_next[w_dest] = 1'b1;
    end
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge of_clk or negedge of_ares_n) begin
    if (!of_ares_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_instr   <= '0;
      r_ex_pc      <= '0;
      r_ex_rs1_val <= '0;
      r_ex_rs2_val <= '0;
      r_ex_rd      <= '0;
      r_ex_illegal <= 1'b0;
      r_sb         <= '0;
    end else begin
      r_sb <= w_sb_next;
      if (w_accept) begin
        r_ex_valid   <= 1'b1;
        r_ex_instr   <= if_instr;
        r_ex_pc      <= if_pc;
        r_ex_rs1_val <= w_op_a;
        r_ex_rs2_val <= w_op_b;
        r_ex_rd      <= w_dest;
        r_ex_illegal <= w_illegal;
      end else if (ex_ready) begin
        r_ex_valid   <= 1'b0;
      end
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_instr   = r_ex_instr;
  assign ex_pc      = r_ex_pc;
  assign ex_rs1_val = r_ex_rs1_val;
  assign ex_rs2_val = r_ex_rs2_val;
  assign ex_rd      = r_ex_rd;
  assign ex_illegal = r_ex_illegal;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch_stage
// Purpose  : Self-checking bench for operand_fetch_stage: directed scenarios
//            followed by a random instruction/writeback stream, compared
//            against a behavioural model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;

  logic        of_clk;
  logic        of_ares_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rf_ra_dec;
  logic [4:0]  rf_rb_dec;
  logic [31:0] rf_qa;
  logic [31:0] rf_qb;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_illegal;

  operand_fetch_stage #(.XLEN(32), .ADDR_WIDTH(5), .PC_W(32)) dut (
    .of_clk     (of_clk),
    .of_ares_n  (of_ares_n),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .rf_ra_dec  (rf_ra_dec),
    .rf_rb_dec  (rf_rb_dec),
    .rf_qa      (rf_qa),
    .rf_qb      (rf_qb),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_instr   (ex_instr),
    .ex_pc      (ex_pc),
    .ex_rs1_val (ex_rs1_val),
    .ex_rs2_val (ex_rs2_val),
    .ex_rd      (ex_rd),
    .ex_illegal (ex_illegal)
  );

  initial begin
    of_clk = 1'b0;
    forever #5 of_clk = ~of_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_pend[32];
  logic        m_v;
  logic [31:0] m_instr, m_pc, m_a, m_b;
  logic [4:0]  m_rd;
  logic        m_ill;

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_v = 1'b0; m_instr = '0; m_pc = '0; m_a = '0; m_b = '0; m_rd = '0; m_ill = 1'b0;
  endtask

  // Which register roles an opcode has, straight from the RV32I opcode map.
  function automatic void classify(input logic [6:0] opc, output bit r1, output bit r2,
                                   output bit wr, output bit ill);
    r1 = 0; r2 = 0; wr = 0; ill = 0;
    case (opc)
      7'h37, 7'h17, 7'h6F: wr = 1;               // LUI AUIPC JAL
      7'h67, 7'h03, 7'h13: begin r1 = 1; wr = 1; end  // JALR LOAD OP-IMM
      7'h63, 7'h23:        begin r1 = 1; r2 = 1; end  // BRANCH STORE
      7'h33:               begin r1 = 1; r2 = 1; wr = 1; end  // OP
      default:             ill = 1;
    endcase
  endfunction

  function automatic logic [31:0] operand(input bit used, input logic [4:0] idx,
                                          input logic [31:0] rf, input logic we,
                                          input logic [4:0] wrd, input logic [31:0] wd);
    if (!used || idx == 0) return 32'h0;
    if (we && wrd == idx)  return wd;
    return rf;
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, "_ex_valid"},   {31'h0, ex_valid},   {31'h0, m_v});
    check({pfx, "_ex_instr"},   ex_instr,            m_instr);
    check({pfx, "_ex_pc"},      ex_pc,               m_pc);
    check({pfx, "_ex_rs1_val"}, ex_rs1_val,          m_a);
    check({pfx, "_ex_rs2_val"}, ex_rs2_val,          m_b);
    check({pfx, "_ex_rd"},      {27'h0, ex_rd},      {27'h0, m_rd});
    check({pfx, "_ex_illegal"}, {31'h0, ex_illegal}, {31'h0, m_ill});
    check({pfx, "_scoreboard"}, dut.r_sb,            pend_vec());
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] qa, input logic [31:0] qb, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd, input logic exr,
                       input string tag);
    logic [4:0] rs1, rs2, rd;
    bit         r1, r2, wr, ill, hz, rdy, acc;
    if_valid = v; if_instr = instr; if_pc = pc; rf_qa = qa; rf_qb = qb;
    wb_en = we; wb_rd = wrd; wb_data = wd; ex_ready = exr;
    rs1 = instr[19:15]; rs2 = instr[24:20]; rd = instr[11:7];
    classify(instr[6:0], r1, r2, wr, ill);
    hz  = (r1 && rs1 != 0 && m_pend[rs1] && !(we && wrd == rs1)) ||
          (r2 && rs2 != 0 && m_pend[rs2] && !(we && wrd == rs2));
    rdy = !hz && (!m_v || exr);
    acc = v && rdy;
    #1;
    check({tag, "_if_ready"}, {31'h0, if_ready}, {31'h0, rdy});
    check({tag, "_ra_dec"}, {27'h0, rf_ra_dec}, {27'h0, rs1});
    check({tag, "_rb_dec"}, {27'h0, rf_rb_dec}, {27'h0, rs2});
    if (acc) begin
      m_v = 1; m_instr = instr; m_pc = pc; m_ill = ill;
      m_a = operand(r1, rs1, qa, we, wrd, wd);
      m_b = operand(r2, rs2, qb, we, wrd, wd);
      m_rd = (wr && rd != 0) ? rd : 5'd0;
    end else if (exr) begin
      m_v = 0;
    end
    if (we && wrd != 0) m_pend[wrd] = 0;
    if (acc && wr && rd != 0) m_pend[rd] = 1;
    @(posedge of_clk);
    #1;
    check_outputs(tag);
    @(negedge of_clk);
  endtask

  function automatic logic [6:0] pick_opc(input int k);
    case (k)
      0: return 7'h37;  1: return 7'h17;  2: return 7'h6F;  3: return 7'h67;
      4: return 7'h63;  5: return 7'h03;  6: return 7'h23;  7: return 7'h13;
      8: return 7'h33;  9: return 7'h7F; 10: return 7'h0F; 11: return 7'h73;
      default: return 7'h33;
    endcase
  endfunction

  localparam logic [31:0] c_ADDI_X5_7  = 32'h0070_0293;
  localparam logic [31:0] c_ADD_X6_X5  = 32'h0052_8333;
  localparam logic [31:0] c_ADDI_X1_1  = 32'h0010_0093;
  localparam logic [31:0] c_ADDI_X2_2  = 32'h0020_0113;
  localparam logic [31:0] c_LW_X9      = 32'h0000_2483;
  localparam logic [31:0] c_ILLEGAL    = 32'h0063_037F;
  localparam logic [31:0] c_SW_X3_X4   = 32'h0032_2023;

  initial begin
    logic [31:0] sb_before;
    logic [31:0] ins;
    model_reset();
    of_ares_n = 1'b0; if_valid = 0; if_instr = '0; if_pc = '0;
    rf_qa = '0; rf_qb = '0; wb_en = 0; wb_rd = '0; wb_data = '0; ex_ready = 0;
    #1;
    check_outputs("por");
    @(negedge of_clk); @(negedge of_clk);
    of_ares_n = 1'b1;

    // RAW stall on x5, then release through same-cycle writeback bypass
    cycle(1, c_ADDI_X5_7, 32'h100, 32'h11, 32'h22, 0, 0, 0, 1, "t2_addi");
    cycle(1, c_ADD_X6_X5, 32'h104, 32'h55, 32'h66, 0, 0, 0, 1, "t2_stall");
    check("t2_stalled_ready_low", {31'h0, if_ready}, 32'h0);
    cycle(1, c_ADD_X6_X5, 32'h104, 32'h55, 32'h66, 1, 5, 32'd7, 1, "t2_byp");
    check("t2_rs1_bypass", ex_rs1_val, 32'd7);
    check("t2_rs2_bypass", ex_rs2_val, 32'd7);
    check("t2_sb6_set",   {31'h0, dut.r_sb[6]}, 32'h1);
    check("t2_sb5_clear", {31'h0, dut.r_sb[5]}, 32'h0);

    // x0 source reads zero even with rf data and a writeback to x0
    cycle(1, c_ADDI_X1_1, 32'h108, 32'hDEAD, 32'h0, 1, 0, 32'h1234, 1, "t3");
    check("t3_rs1_x0_zero", ex_rs1_val, 32'h0);

    // Execute back-pressure holds the payload
    for (int i = 0; i < 3; i++) begin
      cycle(1, c_ADDI_X2_2, 32'h10C, 32'h0, 32'h0, 0, 0, 0, 0, "t4_hold");
      check("t4_held_instr", ex_instr, c_ADDI_X1_1);
    end
    cycle(1, c_ADDI_X2_2, 32'h10C, 32'h0, 32'h0, 0, 0, 0, 1, "t4_go");
    check("t4_loaded_instr", ex_instr, c_ADDI_X2_2);

    // New writer and old writeback of x9 in one cycle: stays pending
    cycle(1, c_LW_X9, 32'h110, 32'h0, 32'h0, 1, 9, 32'h99, 1, "t5");
    check("t5_sb9_set", {31'h0, dut.r_sb[9]}, 32'h1);

    // Illegal opcode ignores pending fields; store writes nothing
    cycle(1, c_ILLEGAL, 32'h114, 32'h1, 32'h2, 0, 0, 0, 1, "t6_ill");
    check("t6_illegal",   {31'h0, ex_illegal}, 32'h1);
    check("t6_ill_rd",    {27'h0, ex_rd},      32'h0);
    sb_before = pend_vec();
    cycle(1, c_SW_X3_X4, 32'h118, 32'h3, 32'h4, 0, 0, 0, 1, "t6_sw");
    check("t6_sw_rd", {27'h0, ex_rd}, 32'h0);
    check("t6_sw_sb", dut.r_sb, sb_before);

    // Asynchronous reset mid-stream, checked before any clock edge
    cycle(1, c_ADDI_X2_2, 32'h11C, 32'h0, 32'h0, 0, 0, 0, 1, "t1_pre");
    check("t1_pre_valid", {31'h0, ex_valid}, 32'h1);
    of_ares_n = 1'b0;
    model_reset();
    #1;
    check_outputs("t1_async");
    @(posedge of_clk); @(negedge of_clk);
    of_ares_n = 1'b1;

    // Random stream on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0]   = pick_opc($urandom_range(0, 12));
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cycle(($urandom_range(0, 3) != 0), ins, $urandom, $urandom, $urandom,
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
